// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory controller: access sizes,
// FSM states, requester identities, alignment and byte-lane helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT_RD,
    ST_RESP
  } state_t;

  typedef enum logic {
    SRC_CPU,
    SRC_DBG
  } src_t;

  // Size encoding 11 is never legal; halves need an even lane, words lane 0.
  function automatic logic size_fault(input logic [1:0] size, input logic [1:0] lane);
    logic f;
    case (size)
      SZ_B:    f = 1'b0;
      SZ_H:    f = lane[0];
      SZ_W:    f = |lane;
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] base;
    case (size)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/dmem_lsu_arbiter_align.sv
// Purely combinational CPU access shaping: fault detect, byte enables and
// write replication on the request side, lane extract and extend on loads.
module lsu_align
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [1:0]         req_size,
  input  logic [1:0]         req_lane,
  input  logic [31:ADDR_W+2] req_addr_hi,
  input  logic [31:0]        req_wdata,
  output logic               req_fault,
  output logic [3:0]         req_be,
  output logic [31:0]        req_wdata_rep,
  input  logic [1:0]         ld_size,
  input  logic [1:0]         ld_lane,
  input  logic               ld_unsigned,
  input  logic [31:0]        ld_raw,
  output logic [31:0]        ld_data
);

  logic [31:0] ld_shift;

  assign req_fault = size_fault(req_size, req_lane) | (|req_addr_hi);
  assign req_be    = lane_mask(req_size, req_lane);
  assign ld_shift  = ld_raw >> {ld_lane, 3'b000};

  // Replicating across lanes lets the memory pick any lane via byte enables.
  always_comb begin
    req_wdata_rep = req_wdata;
    case (req_size)
      SZ_B:    req_wdata_rep = {4{req_wdata[7:0]}};
      SZ_H:    req_wdata_rep = {2{req_wdata[15:0]}};
      default: req_wdata_rep = req_wdata;
    endcase
  end

  always_comb begin
    ld_data = ld_raw;
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_unsigned & ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data = {{16{~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_arbiter.sv
// Single-port data-memory controller: round-robin CPU/debug arbitration,
// one access at a time through IDLE->ACCESS->(WAIT_RD)->RESP.
module dmem_lsu_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_rsp_valid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_fault,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_rsp_valid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state;
  src_t        last_grant;
  src_t        src_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        cpu_grant;
  logic        dbg_grant;
  logic        req_fault;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;
  logic [31:0] ld_data;

  // On contention the requester not served last time wins.
  assign cpu_grant     = cpu_req_valid & (~dbg_req_valid | (last_grant == SRC_DBG));
  assign dbg_grant     = dbg_req_valid & ~cpu_grant;
  assign cpu_req_ready = (state == ST_IDLE) & cpu_grant;
  assign dbg_req_ready = (state == ST_IDLE) & dbg_grant;

  lsu_align #(.ADDR_W(ADDR_W)) u_align (
    .req_size      (cpu_size),
    .req_lane      (cpu_addr[1:0]),
    .req_addr_hi   (cpu_addr[31:ADDR_W+2]),
    .req_wdata     (cpu_wdata),
    .req_fault     (req_fault),
    .req_be        (req_be),
    .req_wdata_rep (req_wdata_rep),
    .ld_size       (size_q),
    .ld_lane       (lane_q),
    .ld_unsigned   (uns_q),
    .ld_raw        (mem_rdata),
    .ld_data       (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last_grant    <= SRC_DBG;
      src_q         <= SRC_CPU;
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= SZ_B;
      lane_q        <= 2'b00;
      cpu_rsp_valid <= 1'b0;
      cpu_rdata     <= '0;
      cpu_fault     <= 1'b0;
      dbg_rsp_valid <= 1'b0;
      dbg_rdata     <= '0;
      mem_en        <= 1'b0;
      mem_we        <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_grant) begin
            last_grant <= SRC_CPU;
            src_q      <= SRC_CPU;
            we_q       <= cpu_we;
            uns_q      <= cpu_unsigned;
            size_q     <= cpu_size;
            lane_q     <= cpu_addr[1:0];
            if (req_fault) begin
              // Faults skip the memory entirely and answer next cycle.
              cpu_rsp_valid <= 1'b1;
              cpu_fault     <= 1'b1;
              cpu_rdata     <= '0;
              state         <= ST_RESP;
            end else begin
              mem_en    <= 1'b1;
              mem_addr  <= cpu_addr[ADDR_W+1:2];
              mem_we    <= cpu_we ? req_be : 4'b0000;
              mem_wdata <= req_wdata_rep;
              state     <= ST_ACCESS;
            end
          end else if (dbg_grant) begin
            last_grant <= SRC_DBG;
            src_q      <= SRC_DBG;
            we_q       <= dbg_we;
            mem_en     <= 1'b1;
            mem_addr   <= dbg_addr;
            mem_we     <= dbg_we ? 4'b1111 : 4'b0000;
            mem_wdata  <= dbg_wdata;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= '0;
          if (we_q) begin
            cpu_rsp_valid <= (src_q == SRC_CPU);
            dbg_rsp_valid <= (src_q == SRC_DBG);
            state         <= ST_RESP;
          end else begin
            state <= ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          if (src_q == SRC_CPU) begin
            cpu_rsp_valid <= 1'b1;
            cpu_rdata     <= ld_data;
          end else begin
            dbg_rsp_valid <= 1'b1;
            dbg_rdata     <= mem_rdata;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          cpu_rsp_valid <= 1'b0;
          cpu_rdata     <= '0;
          cpu_fault     <= 1'b0;
          dbg_rsp_valid <= 1'b0;
          dbg_rdata     <= '0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_arbiter.sv
// Bench for dmem_lsu_arbiter: behavioural byte-array memory model plus a
// negedge monitor that predicts every memory strobe and response.
module tb_dmem_lsu_arbiter;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req_valid, cpu_req_ready, cpu_we, cpu_unsigned;
  logic [1:0]        cpu_size;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic              cpu_rsp_valid, cpu_fault;
  logic              dbg_req_valid, dbg_req_ready, dbg_we, dbg_rsp_valid;
  logic [ADDR_W-1:0] dbg_addr, mem_addr;
  logic [31:0]       dbg_wdata, dbg_rdata, mem_wdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [31:0]       mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_lsu_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_we(cpu_we),
    .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rsp_valid(cpu_rsp_valid), .cpu_rdata(cpu_rdata),
    .cpu_fault(cpu_fault), .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rdata(dbg_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory the DUT drives; the reference keeps its own byte-level copy.
  logic [31:0] mem   [DEPTH];
  logic [7:0]  ref_b [4*DEPTH];

  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      if (mem_we == 4'b0000) mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected outcome of the single outstanding transaction.
  logic              pend = 1'b0;
  logic              p_dbg, p_fault, p_chk_rdata, p_en_seen;
  int                p_en, p_rsp;
  logic [3:0]        p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [31:0]       p_wdata, p_rdata;
  int                n_rsp = 0;
  int                gq[$];
  logic [31:0]       last_cpu_rdata;
  logic              last_cpu_fault;
  logic [3:0]        last_we;
  logic [31:0]       last_wd;

  task automatic model_cpu(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
    int nb, ba;
    logic [63:0] v;
    logic flt;
    p_dbg = 1'b0; p_chk_rdata = 1'b1; p_en_seen = 1'b0; p_rdata = '0;
    flt = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
          || ((a >> (ADDR_W + 2)) != 0);
    p_fault = flt;
    if (flt) begin
      p_rsp = cyc + 1; p_en = -1;
    end else begin
      nb = 1 << sz;
      ba = int'(a[ADDR_W+1:0]);
      p_en = cyc + 1;
      p_addr = a[ADDR_W+1:2];
      if (we) begin
        p_rsp = cyc + 2;
        p_we = 4'(((1 << nb) - 1) << a[1:0]);
        p_wdata = (nb == 1) ? wd[7:0] * 32'h01010101 :
                  (nb == 2) ? wd[15:0] * 32'h00010001 : wd;
        for (int i = 0; i < nb; i++) ref_b[ba+i] = wd[8*i +: 8];
      end else begin
        p_rsp = cyc + 3; p_we = 4'b0000; v = '0;
        for (int i = 0; i < nb; i++) v = v | (64'(ref_b[ba+i]) << (8*i));
        if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        p_rdata = v[31:0];
      end
    end
    pend = 1'b1;
  endtask

  task automatic model_dbg(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    int ba;
    ba = 4 * int'(a);
    p_dbg = 1'b1; p_fault = 1'b0; p_en_seen = 1'b0; p_chk_rdata = !we;
    p_en = cyc + 1; p_addr = a; p_wdata = wd; p_rdata = '0;
    if (we) begin
      p_rsp = cyc + 2; p_we = 4'b1111;
      for (int i = 0; i < 4; i++) ref_b[ba+i] = wd[8*i +: 8];
    end else begin
      p_rsp = cyc + 3; p_we = 4'b0000;
      p_rdata = {ref_b[ba+3], ref_b[ba+2], ref_b[ba+1], ref_b[ba]};
    end
    pend = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (cpu_req_ready && dbg_req_ready) chk("dual_ready", 1, 0);
      if (pend) begin
        if (mem_en) begin
          p_en_seen = 1'b1;
          chk("mem_en_cycle", cyc, p_en);
          chk("mem_we", mem_we, p_we);
          chk("mem_addr", mem_addr, p_addr);
          if (p_we != 4'b0000) chk("mem_wdata", mem_wdata, p_wdata);
          last_we = mem_we; last_wd = mem_wdata;
        end
        if (cpu_rsp_valid || dbg_rsp_valid) begin
          n_rsp++;
          chk("rsp_cycle", cyc, p_rsp);
          chk("rsp_src", {cpu_rsp_valid, dbg_rsp_valid}, p_dbg ? 2'b01 : 2'b10);
          if (p_en >= 0) chk("mem_en_seen", p_en_seen, 1);
          if (cpu_rsp_valid) begin
            chk("cpu_rdata", cpu_rdata, p_rdata);
            chk("cpu_fault", cpu_fault, p_fault);
            last_cpu_rdata = cpu_rdata; last_cpu_fault = cpu_fault;
          end else if (p_chk_rdata) begin
            chk("dbg_rdata", dbg_rdata, p_rdata);
          end
          pend = 1'b0;
        end else if (cyc > p_rsp) begin
          chk("rsp_timeout", 0, 1);
          pend = 1'b0;
        end
      end else if (mem_en || cpu_rsp_valid || dbg_rsp_valid) begin
        n_rsp++;
        chk("spurious_activity", 1, 0);
      end
      if (cpu_req_valid && cpu_req_ready) begin
        gq.push_back(0);
        model_cpu(cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata);
      end else if (dbg_req_valid && dbg_req_ready) begin
        gq.push_back(1);
        model_dbg(dbg_we, dbg_addr, dbg_wdata);
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    cpu_we = we; cpu_size = sz; cpu_unsigned = uns; cpu_addr = a; cpu_wdata = wd;
    cpu_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cpu_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!cpu_req_ready) chk("cpu_ready_timeout", 0, 1);
    @(posedge clk); #1 cpu_req_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic dbg_op(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!dbg_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!dbg_req_ready) chk("dbg_ready_timeout", 0, 1);
    @(posedge clk); #1 dbg_req_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int n, snap;
    logic [31:0] ra;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < 4*DEPTH; i++) ref_b[i] = '0;
    cpu_req_valid = 0; cpu_we = 0; cpu_size = 0; cpu_unsigned = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem", {mem_en, mem_we, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu", {cpu_rsp_valid, cpu_fault, cpu_req_ready}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg", {dbg_rsp_valid, dbg_req_ready}, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);

    // Both requesters held valid from reset: grants must alternate, CPU first.
    cpu_we = 0; cpu_size = 2'd2; cpu_addr = 32'h20;
    dbg_we = 1; dbg_addr = 8'd9; dbg_wdata = 32'h55AA00FF;
    cpu_req_valid = 1; dbg_req_valid = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (gq.size() < 8 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 cpu_req_valid = 0; dbg_req_valid = 0;
    repeat (6) @(posedge clk);
    chk("rr_grants", gq.size() >= 8, 1);
    for (int i = 0; i < gq.size(); i++) chk("rr_order", gq[i], i % 2);
    chk("rr_rsp_count", n_rsp, gq.size());

    cpu_op(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    cpu_op(0, 2'd2, 0, 32'h10, 0);
    chk("t1_load_word", last_cpu_rdata, 32'hDEADBEEF);

    cpu_op(1, 2'd0, 0, 32'h13, 32'h80);
    chk("t2_byte_we", last_we, 4'b1000);
    chk("t2_byte_wdata", last_wd, 32'h80808080);
    cpu_op(0, 2'd0, 0, 32'h13, 0);
    chk("t2_lb", last_cpu_rdata, 32'hFFFFFF80);
    cpu_op(0, 2'd0, 1, 32'h13, 0);
    chk("t2_lbu", last_cpu_rdata, 32'h00000080);
    cpu_op(0, 2'd2, 0, 32'h10, 0);
    chk("t2_lw", last_cpu_rdata, 32'h80ADBEEF);

    cpu_op(0, 2'd1, 0, 32'h11, 0);
    chk("t3_half_mis", {last_cpu_fault, last_cpu_rdata}, {1'b1, 32'h0});
    cpu_op(0, 2'd2, 0, 32'h12, 0);
    chk("t3_word_mis", {last_cpu_fault, last_cpu_rdata}, {1'b1, 32'h0});
    cpu_op(0, 2'd3, 0, 32'h10, 0);
    chk("t3_size_ill", {last_cpu_fault, last_cpu_rdata}, {1'b1, 32'h0});
    cpu_op(0, 2'd2, 0, 32'h400, 0);
    chk("t3_range", {last_cpu_fault, last_cpu_rdata}, {1'b1, 32'h0});

    dbg_op(1, 8'd3, 32'h1234ABCD);
    cpu_op(0, 2'd1, 0, 32'h0E, 0);
    chk("t5_lh_hi", last_cpu_rdata, 32'h00001234);
    cpu_op(0, 2'd1, 0, 32'h0C, 0);
    chk("t5_lh_lo", last_cpu_rdata, 32'hFFFFABCD);

    // Reset while the read data is in flight: no response may follow.
    @(posedge clk); #1;
    cpu_we = 0; cpu_size = 2'd2; cpu_unsigned = 0; cpu_addr = 32'h10; cpu_req_valid = 1;
    n = 0;
    @(negedge clk);
    while (!cpu_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!cpu_req_ready) chk("t6_ready_timeout", 0, 1);
    @(posedge clk); #1 cpu_req_valid = 0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    snap = n_rsp;
    chk("t6_rst_outs", {mem_en, mem_we, cpu_rsp_valid, cpu_fault, dbg_rsp_valid}, 0);
    chk("t6_rst_rdata", cpu_rdata, 0);
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    chk("t6_no_rsp", n_rsp, snap);
    cpu_op(0, 2'd2, 0, 32'h10, 0);
    chk("t6_reload", last_cpu_rdata, 32'h80ADBEEF);

    for (int it = 0; it < 300; it++) begin
      ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      case ($urandom_range(0, 2))
        0: cpu_op(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom);
        1: dbg_op(1'($urandom), 8'($urandom_range(0, 15)), $urandom);
        default: fork
          cpu_op(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom);
          dbg_op(1'($urandom), 8'($urandom_range(0, 15)), $urandom);
        join
      endcase
    end
    repeat (6) @(posedge clk);
    chk("end_idle", pend, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_arbiter.md
Name: dmem_lsu_arbiter

Overview:
Controller in front of the single-port data memory (32-bit words, byte-enable write, 1-cycle synchronous read).
- Arbitrates between two requesters:
  - the core's MEM stage (byte/half/word, signed/unsigned);
  - a debug/program-loader port (word-only).
- Generates byte enables and lane-replicated write data.
- Extracts and extends load data.
- Flags misaligned and out-of-range accesses.
- Sequences every access through a small FSM with valid/ready requests and a one-cycle response pulse.

Parameters:
ADDR_W, 8, word-address width of the memory (DEPTH = 2**ADDR_W words)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  CPU request accepted this cycle
cpu_we  in  1  1=store, 0=load
cpu_size  in  2  00=byte, 01=half, 10=word, 11=illegal
cpu_unsigned  in  1  zero-extend loads when 1
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, right-aligned
cpu_rsp_valid  out  1  one-cycle completion pulse
cpu_rdata  out  32  extended load data (0 for stores/faults)
cpu_fault  out  1  qualifies cpu_rsp_valid; misaligned/illegal/out-of-range
dbg_req_valid  in  1  debug request present
dbg_req_ready  out  1  debug request accepted
dbg_we  in  1  1=write word
dbg_addr  in  ADDR_W  word address
dbg_wdata  in  32  write data
dbg_rsp_valid  out  1  one-cycle completion pulse
dbg_rdata  out  32  read word
mem_en  out  1  memory access strobe
mem_we  out  4  byte write enables (bit i = byte lane i)
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  lane-replicated write data
mem_rdata  in  32  read data, valid cycle after mem_en with mem_we=0

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=DBG (CPU wins first contention).
- FSM states: IDLE, ACCESS, WAIT_RD, RESP.
- IDLE:
  - Arbitrate among valid requesters: round-robin when both are valid, otherwise the only valid one.
  - Assert ready to the winner only, combinationally, in IDLE only. Handshake = valid & ready.
  - Latch the request, including the decoded source, and update last_grant.
  - Faulting CPU request -> RESP directly; otherwise -> ACCESS.
- ACCESS:
  - mem_en=1 with registered mem_addr/mem_we/mem_wdata.
  - Store -> RESP; load -> WAIT_RD.
- WAIT_RD: capture mem_rdata, format it -> RESP.
- RESP: pulse rsp_valid of the latched source for 1 cycle with rdata/fault -> IDLE. No back-pressure on responses.
- Latency (handshake in cycle T):
  - store: mem_en at T+1, rsp at T+2;
  - load: mem_en at T+1, rsp at T+3;
  - fault: rsp at T+1, mem_en never asserted.
- Throughput: one transaction per 3-4 cycles; no pipelining.
- CPU byte lane = addr[1:0], word address = addr[ADDR_W+1:2].
  - Byte store: mem_we = 0001<<lane, mem_wdata = {4{wdata[7:0]}}.
  - Half store: addr[0] must be 0; mem_we = 0011<<lane, mem_wdata = {2{wdata[15:0]}}.
  - Word store: addr[1:0] must be 00; mem_we = 1111.
- Loads: select the lane, then sign-extend (cpu_unsigned=0) or zero-extend.
- Fault conditions:
  - size=11;
  - misaligned half or word;
  - any of addr[31:ADDR_W+2] nonzero.
- Fault response: rsp_valid with fault=1, rdata=0, memory untouched.
- Debug port: always word access, mem_we=1111 for writes, never faults. dbg_rdata = raw word.
- Requests arriving outside IDLE see ready=0 and must hold.
- rst_n assertion in any state:
  - forces IDLE and zeroes outputs asynchronously;
  - the in-flight transaction is dropped with no response;
  - a store in ACCESS may or may not have been written.

Decomposition:
- Package dmem_pkg holds:
  - size encodings (SZ_B/SZ_H/SZ_W);
  - state enum;
  - source enum (SRC_CPU/SRC_DBG);
  - fault-check and lane helper functions.
- One combinational sub-module, lsu_align: byte-enable generation, write replication, load extract/extend, fault detect. The top holds the FSM, arbiter and registers.

Test Plan:
1. CPU store word 0xDEADBEEF @0x10, then load word @0x10 -> store: mem_we=1111, mem_addr=4, rsp at T+2; load: rdata=0xDEADBEEF at T+3, fault=0.
2. Store byte 0x80 @0x13 -> mem_we=1000, mem_wdata=0x80808080. Subsequent loads:
   - signed byte @0x13 -> 0xFFFFFF80;
   - unsigned byte @0x13 -> 0x00000080;
   - word @0x10 -> 0x80ADBEEF.
3. Half load @0x11, word load @0x12, size=11, and load @0x400 (ADDR_W=8) -> each returns fault=1, rdata=0 at T+1, mem_en stays 0.
4. cpu and dbg valid continuously from reset -> grants alternate CPU, DBG, CPU, DBG; no duplicate or lost responses.
5. dbg write 0x1234ABCD to word 3, then CPU signed half load @0x0E -> rdata=0x00001234; @0x0C -> 0xFFFFABCD.
6. rst_n low during WAIT_RD -> outputs 0 immediately, no rsp after release; the next CPU load completes normally with correct data.
